// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes every datapath enable from the current state. Optional build macro: ILLEGAL_TRAP_EN.
module mips_multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             aluzero,
    output logic [2:0]       alucontrol_signal,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic             pc_en,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic             illegal_op
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic             w_pcwrite;
    logic             w_branch;
    logic             w_retire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Only terminal states (and a NOP'd decode) ever return to FETCH, so that edge marks retirement.
    assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_retire) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    always_comb begin
        w_next            = r_state;
        alucontrol_signal = ALU_ADD;
        alusrca           = 1'b0;
        alusrcb           = 2'b00;
        pcsrc             = 2'b00;
        w_pcwrite         = 1'b0;
        w_branch          = 1'b0;
        iord              = 1'b0;
        memread           = 1'b0;
        memwrite          = 1'b0;
        irwrite           = 1'b0;
        regdst            = 1'b0;
        memtoreg          = 1'b0;
        regwrite          = 1'b0;
        case (r_state)
            S_FETCH: begin
                memread   = 1'b1;
                irwrite   = 1'b1;
                w_pcwrite = 1'b1;
                alusrcb   = 2'b01;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEXEC;
                    OP_J:         w_next = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
                    default:      w_next = S_TRAP;
`else
                    default:      w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                memread = 1'b1;
                iord    = 1'b1;
                w_next  = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEMWRITE: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                w_next   = S_FETCH;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                w_next  = S_ALUWB;
                case (funct)
                    6'b100000: alucontrol_signal = ALU_ADD;
                    6'b100010: alucontrol_signal = ALU_SUB;
                    6'b100100: alucontrol_signal = ALU_AND;
                    6'b100101: alucontrol_signal = ALU_OR;
                    6'b101010: alucontrol_signal = ALU_SLT;
                    default: begin
                        alucontrol_signal = ALU_ADD;
`ifdef ILLEGAL_TRAP_EN
                        w_next = S_TRAP;
`endif
                    end
                endcase
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                alusrca           = 1'b1;
                alucontrol_signal = ALU_SUB;
                pcsrc             = 2'b01;
                w_branch          = 1'b1;
                w_next            = S_FETCH;
            end
            S_ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_JUMP: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
                w_next    = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
        // State is already FETCH during reset; suppress its strobes so nothing fires while held.
        if (reset) begin
            alucontrol_signal = ALU_ADD;
            alusrca           = 1'b0;
            alusrcb           = 2'b00;
            pcsrc             = 2'b00;
            w_pcwrite         = 1'b0;
            w_branch          = 1'b0;
            iord              = 1'b0;
            memread           = 1'b0;
            memwrite          = 1'b0;
            irwrite           = 1'b0;
            regdst            = 1'b0;
            memtoreg          = 1'b0;
            regwrite          = 1'b0;
        end
    end

    assign pc_en       = w_pcwrite | (w_branch & aluzero);
    assign state       = r_state;
    assign instr_count = r_count;

`ifdef ILLEGAL_TRAP_EN
    assign illegal_op = !reset && (r_state == S_TRAP);
`endif

endmodule
